// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_arb_pkg;

    localparam int UART_DATA_W = 8;
    localparam int MAX_REQ     = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } arb_state_t;

    // Callers zero-extend their flat byte bus to the widest supported requester count.
    function automatic logic [UART_DATA_W-1:0] get_byte(
        input logic [UART_DATA_W*MAX_REQ-1:0] bus,
        input int                             k
    );
        return bus[k*UART_DATA_W +: UART_DATA_W];
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker, search starts after last_grant
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic             valid,
    output logic [ID_W-1:0]  winner
);

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % N_REQ]) begin
                valid  = 1'b1;
                winner = ID_W'((int'(last_grant) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter between N_REQ byte requesters
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16,
    parameter int ID_W          = $clog2(N_REQ)
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [8*N_REQ-1:0]     req_data_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   timeout_o,
    output logic                   busy_o,
    output logic [ID_W-1:0]        cur_id_o,
    output logic                   uart_txen_o,
    output logic [UART_DATA_W-1:0] uart_tx_data_o,
    input  logic                   uart_tx_ing_i
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_t             state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx, cnt_inc;
    logic [ID_W-1:0]        last_grant, last_grant_nx;
    logic [ID_W-1:0]        cur_id_nx;
    logic [UART_DATA_W-1:0] data_nx;
    logic                   txen_nx;
    logic [N_REQ-1:0]       ack_nx;
    logic                   timeout_nx;
    logic                   pick_valid;
    logic [ID_W-1:0]        pick_id;
    logic [UART_DATA_W*MAX_REQ-1:0] data_ext;

    assign data_ext = (UART_DATA_W*MAX_REQ)'(req_data_i);
    assign cnt_inc  = cnt + CNT_W'(1);

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req_i),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        cur_id_nx     = cur_id_o;
        data_nx       = uart_tx_data_o;
        txen_nx       = 1'b0;
        ack_nx        = '0;
        timeout_nx    = 1'b0;
        case (state)
            IDLE: begin
                // A frame still on the wire (stale or foreign) blocks any new grant.
                if (pick_valid && !uart_tx_ing_i) begin
                    data_nx   = get_byte(data_ext, int'(pick_id));
                    cur_id_nx = pick_id;
                    txen_nx   = 1'b1;
                    state_nx  = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_nx   = '0;
                state_nx = WAIT_START;
            end
            WAIT_START: begin
                if (uart_tx_ing_i) begin
                    ack_nx   = N_REQ'(1) << cur_id_o;
                    state_nx = WAIT_DONE;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == CNT_W'(START_TIMEOUT - 1)) begin
                        timeout_nx    = 1'b1;
                        last_grant_nx = cur_id_o;
                        state_nx      = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_ing_i) begin
                    last_grant_nx = cur_id_o;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state          <= IDLE;
            cnt            <= '0;
            last_grant     <= ID_W'(N_REQ - 1);
            cur_id_o       <= '0;
            uart_tx_data_o <= '0;
            uart_txen_o    <= 1'b0;
            ack_o          <= '0;
            timeout_o      <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            last_grant     <= last_grant_nx;
            cur_id_o       <= cur_id_nx;
            uart_tx_data_o <= data_nx;
            uart_txen_o    <= txen_nx;
            ack_o          <= ack_nx;
            timeout_o      <= timeout_nx;
            busy_o         <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        tx_ing = 1'b0;
    logic [3:0]  ack;
    logic        timeout;
    logic        busy;
    logic [1:0]  cur_id;
    logic        txen;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // UART model: tx_ing rises u_dly cycles after txen and stays high for the latched length.
    int u_dly = 2, u_len = 3, cur_len = 3;
    bit u_never = 0, u_force = 0;
    int st_cnt = 0, hold_cnt = 0;

    uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(16)) dut (
        .clock_i        (clk),
        .resetn_i       (resetn),
        .req_i          (req),
        .req_data_i     (req_data),
        .ack_o          (ack),
        .timeout_o      (timeout),
        .busy_o         (busy),
        .cur_id_o       (cur_id),
        .uart_txen_o    (txen),
        .uart_tx_data_o (tx_data),
        .uart_tx_ing_i  (tx_ing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (!u_force) begin
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) begin
                    tx_ing   = 1'b1;
                    hold_cnt = cur_len;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tx_ing = 1'b0;
            end
            if (txen && !u_never) begin
                st_cnt  = u_dly;
                cur_len = u_len;
            end
        end
    endtask

    task automatic uart_clear();
        st_cnt = 0;
        hold_cnt = 0;
        tx_ing = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0;
        req_data = '0;
        u_force = 0;
        u_never = 0;
        repeat (3) cycle();
        uart_clear();
        resetn = 1'b1;
    endtask

    task automatic wait_txen(input string nm, input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            cycle();
            ok = txen;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s no txen within %0d cycles", nm, limit);
        end
    endtask

    task automatic wait_idle(input string nm, input int limit, output logic [3:0] ack_acc);
        bit done = 0;
        ack_acc = '0;
        for (int i = 0; i < limit && !done; i++) begin
            cycle();
            ack_acc = ack_acc | ack;
            done = !busy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s busy still high after %0d cycles", nm, limit);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++)
            if (r[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    typedef struct {
        logic [3:0] req;
        int         id;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [3:0] acc;
        logic [7:0] base;
        int lcyc, to_c, ack_c, acks, bad, t_low;
        int m_last, m_idle_at, launch_cyc, exp_ack_c, exp_to_c, m_w;
        logic [3:0] prev_req;
        logic [31:0] prev_data;
        logic prev_tx, exp_txen;

        tbl[0] = '{req: 4'b1111, id: 0};
        tbl[1] = '{req: 4'b1111, id: 1};
        tbl[2] = '{req: 4'b0001, id: 0};
        tbl[3] = '{req: 4'b1010, id: 1};
        tbl[4] = '{req: 4'b1010, id: 3};
        tbl[5] = '{req: 4'b0110, id: 1};
        tbl[6] = '{req: 4'b1000, id: 3};
        tbl[7] = '{req: 4'b0101, id: 0};
        tbl[8] = '{req: 4'b0101, id: 2};
        tbl[9] = '{req: 4'b0100, id: 2};

        // Reset held in each state, then the first grant must go to requester 0.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            u_dly = 5;
            u_len = 20;
            req_data = 32'h44332211;
            req = 4'b1111;
            if (s >= 1) wait_txen($sformatf("rst_enter_s%0d", s), 10);
            if (s == 2) cycle();
            if (s == 3) repeat (7) cycle();
            resetn = 1'b0;
            for (int i = 0; i < 5; i++) begin
                cycle();
                chk($sformatf("rst_outputs_s%0d", s),
                    {ack, timeout, busy, cur_id, txen, tx_data}, 32'h0);
            end
            uart_clear();
            resetn = 1'b1;
            wait_txen($sformatf("rst_first_s%0d", s), 10);
            chk($sformatf("rst_first_id_s%0d", s), cur_id, 0);
        end

        // Table of rotation vectors; requests drop right after the grant.
        do_reset();
        u_dly = 2;
        u_len = 3;
        for (int i = 0; i < 10; i++) begin
            base = 8'(16 * i + 5);
            for (int k = 0; k < 4; k++) req_data[8*k +: 8] = base + 8'(k);
            req = tbl[i].req;
            wait_txen($sformatf("tbl%0d_txen", i), 20);
            req = '0;
            chk($sformatf("tbl%0d_id", i), cur_id, tbl[i].id);
            chk($sformatf("tbl%0d_byte", i), tx_data, base + 8'(tbl[i].id));
            wait_idle($sformatf("tbl%0d_idle", i), 40, acc);
            chk($sformatf("tbl%0d_ack", i), acc, 32'(4'b0001 << tbl[i].id));
        end

        // Single request with a long frame.
        do_reset();
        u_dly = 3;
        u_len = 870;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        cycle();
        lcyc = cyc;
        chk("single_txen_n1", txen, 1);
        chk("single_data", tx_data, 8'hA5);
        cycle();
        chk("single_txen_one_cycle", txen, 0);
        ack_c = -1;
        for (int i = 0; i < 20 && ack_c < 0; i++) begin
            if (ack != 0) ack_c = cyc;
            else cycle();
        end
        chk("single_ack_value", ack, 4'b0100);
        chk("single_ack_latency", ack_c - lcyc, 4);
        req = '0;
        acks = 0;
        for (int i = 0; i < 1000 && tx_ing; i++) begin
            cycle();
            if (ack != 0) acks++;
        end
        chk("single_ack_once", acks, 0);
        chk("single_busy_at_fall", busy, 1);
        cycle();
        chk("single_busy_after_fall", busy, 0);

        // Full contention: strict rotation of bytes.
        do_reset();
        u_dly = 2;
        u_len = 3;
        req_data = 32'h13121110;
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            wait_txen($sformatf("rr_txen%0d", j), 30);
            chk($sformatf("rr_byte%0d", j), tx_data, 8'h10 + 8'(j % 4));
        end

        // UART never starts: timeout, then rotation moves on.
        do_reset();
        u_never = 1;
        req = 4'b0011;
        wait_txen("to_txen", 10);
        lcyc = cyc;
        chk("to_first_id", cur_id, 0);
        to_c = -1;
        acks = 0;
        for (int i = 0; i < 30 && to_c < 0; i++) begin
            cycle();
            if (ack != 0) acks++;
            if (timeout) to_c = cyc;
        end
        chk("to_latency", to_c - lcyc, 16);
        chk("to_no_ack", acks, 0);
        cycle();
        chk("to_next_txen", txen, 1);
        chk("to_next_id", cur_id, 1);

        // UART busy with a foreign frame while idle.
        do_reset();
        u_force = 1;
        tx_ing = 1'b1;
        req = 4'b1000;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (txen) bad++;
        end
        chk("busy_uart_no_txen", bad, 0);
        tx_ing = 1'b0;
        u_force = 0;
        cycle();
        chk("busy_uart_txen", txen, 1);
        chk("busy_uart_id", cur_id, 3);

        // Reset during WAIT_DONE; the UART keeps its frame going.
        do_reset();
        u_dly = 2;
        u_len = 10;
        req_data[23:16] = 8'h5A;
        req = 4'b0100;
        wait_txen("mid_txen", 10);
        for (int i = 0; i < 10 && ack == 0; i++) cycle();
        chk("mid_ack", ack, 4'b0100);
        req = '0;
        cycle();
        resetn = 1'b0;
        cycle();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_id", cur_id, 0);
        chk("mid_rst_ack", ack, 0);
        resetn = 1'b1;
        req = 4'b0101;
        wait_txen("mid_regrant", 30);
        chk("mid_regrant_id", cur_id, 0);
        t_low = tx_ing;
        chk("mid_regrant_uart_idle", t_low, 0);

        // Randomized traffic against a transaction-level timing model.
        do_reset();
        m_last = 3;
        m_idle_at = cyc;
        launch_cyc = cyc;
        exp_ack_c = -1;
        exp_to_c = -1;
        m_w = 0;
        prev_req = '0;
        prev_data = '0;
        prev_tx = 1'b0;
        u_never = ($urandom_range(7) == 0);
        u_dly = $urandom_range(15, 1);
        u_len = $urandom_range(6, 1);
        for (int n = 0; n < 3000; n++) begin
            cycle();
            exp_txen = (cyc - 1 >= m_idle_at) && (prev_req != 0) && !prev_tx;
            chk("rnd_txen", txen, exp_txen);
            if (exp_txen) begin
                m_w = rr(prev_req, m_last);
                m_last = m_w;
                chk("rnd_id", cur_id, m_w);
                chk("rnd_byte", tx_data, prev_data[8*m_w +: 8]);
                launch_cyc = cyc;
                if (u_never) begin
                    exp_to_c = cyc + 16;
                    m_idle_at = cyc + 16;
                end else begin
                    exp_ack_c = cyc + u_dly + 1;
                    m_idle_at = cyc + u_dly + u_len + 1;
                end
                u_never = ($urandom_range(7) == 0);
                u_dly = $urandom_range(15, 1);
                u_len = $urandom_range(6, 1);
            end
            chk("rnd_ack", ack, (cyc == exp_ack_c) ? 32'(4'b0001 << m_w) : 32'h0);
            chk("rnd_timeout", timeout, cyc == exp_to_c);
            chk("rnd_busy", busy, (cyc >= launch_cyc) && (cyc < m_idle_at));
            for (int k = 0; k < 4; k++) begin
                if ((cyc == exp_ack_c || cyc == exp_to_c) && k == m_w) req[k] = 1'b0;
                if (!req[k] && $urandom_range(3) == 0) begin
                    req[k] = 1'b1;
                    req_data[8*k +: 8] = 8'($urandom);
                end
            end
            prev_req = req;
            prev_data = req_data;
            prev_tx = tx_ing;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
